// File: rtl/dl_ram_arbiter.sv
// rtl/dl_ram_arbiter.sv - shares one external RAM port between the download path and the CPU
//
// Download bytes are queued in a small FIFO and always win arbitration. The CPU is
// held in reset while a download is active, while the FIFO holds data, and while
// a download write is in flight. Once all of these are clear, the CPU gets plain
// req/ack access to the RAM.
//
// Optional feature: define DL_CHECKSUM_EN to add a 16-bit running sum of the
// downloaded bytes. The sum is exposed on the checksum port.
//
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   dl_active, dl_wr, dl_addr, dl_data   download stream (one-cycle write strobe)
//   cpu_req/we/addr/wdata                CPU request, level, held until cpu_ack
//   cpu_rdata, cpu_ack                   CPU read data, one-cycle completion pulse
//   cpu_reset                            active-high hold-in-reset for the CPU core
//   mem_req/we/addr/wdata                RAM request, registered, held until mem_ack
//   mem_rdata, mem_ack                   RAM read data, one-cycle completion pulse
//   checksum                             (DL_CHECKSUM_EN only) sum of downloaded bytes
//   overflow                             sticky flag: a download byte was dropped
module dl_ram_arbiter #(
    parameter int AW        = 25,
    parameter int DW        = 8,
    parameter int FIFO_LOG2 = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
`ifdef DL_CHECKSUM_EN
    output logic [15:0]   checksum,
`endif
    output logic          overflow
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] FULL_CNT = (FIFO_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DL, S_CPU} state_t;

    state_t state, state_nxt;

    logic [AW+DW-1:0]   fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_LOG2:0] count;
    logic               fifo_empty, fifo_full, push, pop;
    logic [AW+DW-1:0]   head;
    logic               dl_active_q, dl_rise;

    logic          mem_req_nxt, mem_we_nxt, cpu_ack_nxt, cpu_reset_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt, cpu_rdata_nxt;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = (state == S_IDLE) && !fifo_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = dl_wr && (!fifo_full || pop);
    assign head       = fifo_mem[rd_ptr];
    assign dl_rise    = dl_active && !dl_active_q;

    // FIFO storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {dl_addr, dl_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            dl_active_q <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            // A drop in the same cycle as a new download start is still reported.
            if (dl_wr && !push)
                overflow <= 1'b1;
            else if (dl_rise)
                overflow <= 1'b0;
        end
    end

    // State register; the RAM/CPU-side outputs are registered alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            cpu_reset <= 1'b1;
        end else begin
            state     <= state_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            cpu_ack   <= cpu_ack_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            cpu_reset <= cpu_reset_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty)
                    state_nxt = S_DL;
                else if (cpu_req && !cpu_reset)
                    state_nxt = S_CPU;
            end
            S_DL:    if (mem_ack) state_nxt = S_IDLE;
            S_CPU:   if (mem_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        cpu_ack_nxt   = 1'b0;
        cpu_rdata_nxt = cpu_rdata;
        // cpu_reset only gates new grants; an issued CPU access always completes.
        cpu_reset_nxt = dl_active || !fifo_empty || (state == S_DL);
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = head[AW+DW-1:DW];
                    mem_wdata_nxt = head[DW-1:0];
                end else if (cpu_req && !cpu_reset) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = cpu_we;
                    mem_addr_nxt  = cpu_addr;
                    mem_wdata_nxt = cpu_wdata;
                end
            end
            S_DL: begin
                if (mem_ack)
                    mem_req_nxt = 1'b0;
            end
            S_CPU: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    cpu_ack_nxt = 1'b1;
                    if (!mem_we)
                        cpu_rdata_nxt = mem_rdata;
                end
            end
            default: ;
        endcase
    end

`ifdef DL_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            checksum <= 16'h0000;
        else if (dl_rise)
            checksum <= 16'h0000;
        else if (state == S_DL && mem_ack)
            checksum <= checksum + 16'(mem_wdata);
    end
`endif

endmodule

// File: tb/tb_dl_ram_arbiter.sv
// tb/tb_dl_ram_arbiter.sv - directed self-checking bench for dl_ram_arbiter
module tb_dl_ram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        dl_active, dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        cpu_req, cpu_we;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_reset;
    logic        mem_req, mem_we;
    logic [24:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        overflow;
`ifdef DL_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dl_ram_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_reset (cpu_reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
`ifdef DL_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        step(); step();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); end
        n_checks++; if (mem_addr !== 25'h0 || mem_wdata !== 8'h0 || cpu_rdata !== 8'h0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs: addr=%h wdata=%h rdata=%h we=%b want all 0", mem_addr, mem_wdata, cpu_rdata, mem_we);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_download();
        logic [7:0] dd [3];
        bit ok;
        dd[0] = 8'hA5; dd[1] = 8'h5A; dd[2] = 8'hFF;
        dl_active = 1'b1;
        step();
        n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL dl_cpu_reset_hold: got %b want 1", cpu_reset); end
        for (int i = 0; i < 3; i++) begin
            dl_wr = 1'b1; dl_addr = 25'h010000 + 25'(i); dl_data = dd[i];
            step();
        end
        dl_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_mem_req(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL dl_req_timeout[%0d]: no mem_req within budget", i); end
            n_checks++; if (mem_we !== 1'b1 || mem_addr !== 25'h010000 + 25'(i) || mem_wdata !== dd[i]) begin
                n_fail++; $display("FAIL dl_write[%0d]: we=%b addr=%h data=%h want 1 %h %h", i, mem_we, mem_addr, mem_wdata, 25'h010000 + 25'(i), dd[i]);
            end
            step(); step();
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL dl_req_drop[%0d]: got %b want 0", i, mem_req); end
        end
        dl_active = 1'b0;
        n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL dl_cpu_reset_late: got %b want 1", cpu_reset); end
        step();
        n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL dl_cpu_reset_release: got %b want 0", cpu_reset); end
    endtask

    task automatic test_overflow();
        bit ok;
        dl_active = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            dl_wr = 1'b1; dl_addr = 25'h000100 + 25'(i); dl_data = 8'h10 + 8'(i);
            step();
            if (i == 4) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        dl_wr = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
        for (int k = 0; k < 5; k++) begin
            wait_mem_req(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_req_timeout[%0d]: no mem_req within budget", k); end
            n_checks++; if (mem_addr !== 25'h000100 + 25'(k) || mem_wdata !== 8'h10 + 8'(k)) begin
                n_fail++; $display("FAIL ovf_order[%0d]: addr=%h data=%h want %h %h", k, mem_addr, mem_wdata, 25'h000100 + 25'(k), 8'h10 + 8'(k));
            end
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        step(); step();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped_issued: mem_req=%b addr=%h want 0", mem_req, mem_addr); end
        dl_active = 1'b0;
        step();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        dl_active = 1'b1;
        step();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        dl_active = 1'b0;
        step(); step();
    endtask

    task automatic test_cpu_access();
        n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL cpu_pre_reset: got %b want 0", cpu_reset); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h000123;
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 25'h000123) begin
            n_fail++; $display("FAIL cpu_rd_issue: req=%b we=%b addr=%h want 1 0 000123", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        step();
        mem_ack = 1'b0; mem_rdata = 8'h00; cpu_req = 1'b0;
        n_checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h3C) begin
            n_fail++; $display("FAIL cpu_rd_ack: ack=%b rdata=%h want 1 3c", cpu_ack, cpu_rdata);
        end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_req_drop: got %b want 0", mem_req); end
        step();
        n_checks++; if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h3C || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL cpu_rd_after: ack=%b rdata=%h req=%b want 0 3c 0", cpu_ack, cpu_rdata, mem_req);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h000456; cpu_wdata = 8'h99;
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 25'h000456 || mem_wdata !== 8'h99) begin
            n_fail++; $display("FAIL cpu_wr_issue: req=%b we=%b addr=%h data=%h want 1 1 000456 99", mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        step();
        mem_ack = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        n_checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h3C) begin
            n_fail++; $display("FAIL cpu_wr_ack: ack=%b rdata=%h want 1 3c", cpu_ack, cpu_rdata);
        end
        step();
    endtask

    task automatic test_contention();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h000200;
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 25'h000200) begin
            n_fail++; $display("FAIL cont_cpu_issue: req=%b addr=%h want 1 000200", mem_req, mem_addr);
        end
        dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h020000; dl_data = 8'h77;
        step();
        dl_wr = 1'b0;
        n_checks++; if (cpu_reset !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 25'h000200) begin
            n_fail++; $display("FAIL cont_hold: cpu_reset=%b req=%b addr=%h want 1 1 000200", cpu_reset, mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 8'h11;
        step();
        mem_ack = 1'b0; cpu_req = 1'b0;
        n_checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h11 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL cont_cpu_done: ack=%b rdata=%h req=%b want 1 11 0", cpu_ack, cpu_rdata, mem_req);
        end
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 25'h020000 || mem_wdata !== 8'h77 || cpu_ack !== 1'b0) begin
            n_fail++; $display("FAIL cont_dl_issue: req=%b we=%b addr=%h data=%h ack=%b want 1 1 020000 77 0", mem_req, mem_we, mem_addr, mem_wdata, cpu_ack);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; dl_active = 1'b0;
        step(); step();
        n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL cont_release: cpu_reset=%b want 0", cpu_reset); end
    endtask

`ifdef DL_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] dd [3];
        bit ok;
        dd[0] = 8'hFF; dd[1] = 8'hFF; dd[2] = 8'h03;
        dl_active = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            dl_wr = 1'b1; dl_addr = 25'h030000 + 25'(i); dl_data = dd[i];
            step();
        end
        dl_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_mem_req(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL csum_req_timeout[%0d]: no mem_req within budget", i); end
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        n_checks++; if (checksum !== 16'h0201) begin n_fail++; $display("FAIL csum_value: got %h want 0201", checksum); end
        dl_active = 1'b0;
        step();
        dl_active = 1'b1;
        step();
        n_checks++; if (checksum !== 16'h0000) begin n_fail++; $display("FAIL csum_clear: got %h want 0000", checksum); end
        dl_active = 1'b0;
        step(); step();
    endtask
`endif

    task automatic test_reset_mid_access();
        bit ok;
        dl_active = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dl_wr = 1'b1; dl_addr = 25'h040000 + 25'(i); dl_data = 8'h20 + 8'(i);
            step();
        end
        dl_wr = 1'b0;
        wait_mem_req(ok);
        n_checks++; if (!ok || overflow !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: req_seen=%b overflow=%b want 1 1", ok, overflow);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || cpu_reset !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: req=%b cpu_reset=%b overflow=%b want 0 1 0", mem_req, cpu_reset, overflow);
        end
        mem_ack = 1'b1;
        step(); step();
        reset_n = 1'b1; dl_active = 1'b0;
        step();
        mem_ack = 1'b0;
        n_checks++; if (mem_req !== 1'b0 || cpu_ack !== 1'b0 || cpu_reset !== 1'b0) begin
            n_fail++; $display("FAIL rst_after: req=%b ack=%b cpu_reset=%b want 0 0 0", mem_req, cpu_ack, cpu_reset);
        end
        step(); step();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_empty: mem_req=%b addr=%h want 0", mem_req, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_download();
        test_overflow();
        test_cpu_access();
        test_contention();
`ifdef DL_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
